// File: rtl/food_dispense_ctrl_if.sv
// Handshake bundle between the feed controller and its food timer / operator side.
// The master side drives requests and the timer status; the slave side is the controller.
interface food_dispense_ctrl_if #(
   parameter int unsigned PEND_W = 2,
   parameter int unsigned CNT_W  = 4
);
   logic              feed_req;
   logic              fault_clear;
   logic              switch_f_c;
   logic [CNT_W-1:0]  count_in;
   logic              timer_en;
   logic              timer_clr;
   logic              motor_on;
   logic              feed_done;
   logic              busy;
   logic [PEND_W-1:0] pending;
   logic              overflow;
   logic              fault;

   modport master (
      output feed_req, fault_clear, switch_f_c, count_in,
      input  timer_en, timer_clr, motor_on, feed_done, busy, pending, overflow, fault
   );

   modport slave (
      input  feed_req, fault_clear, switch_f_c, count_in,
      output timer_en, timer_clr, motor_on, feed_done, busy, pending, overflow, fault
   );
endinterface

// File: rtl/food_dispense_ctrl.sv
// Feed dispenser controller: queues feed requests, sequences the food timer,
// gates the motor, enforces a cooldown and traps timer misbehaviour in FAULT.
module food_dispense_ctrl #(
   parameter int unsigned FOOD_TIME   = 10,
   parameter int unsigned MAX_PENDING = 3,
   parameter int unsigned ARM_TIMEOUT = 4,
   parameter int unsigned RUN_TIMEOUT = 16,
   parameter int unsigned COOLDOWN    = 5
) (
   input logic                clock,
   input logic                reset,
   food_dispense_ctrl_if.slave bus
);

   localparam int unsigned CNT_W   = 4;
   localparam int unsigned PEND_W  = $clog2(MAX_PENDING + 1);
   localparam int unsigned TMO_MAX0 = (ARM_TIMEOUT > RUN_TIMEOUT) ? ARM_TIMEOUT : RUN_TIMEOUT;
   localparam int unsigned TMO_MAX = (TMO_MAX0 > COOLDOWN) ? TMO_MAX0 : COOLDOWN;
   localparam int unsigned TMO_W   = $clog2(TMO_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_ARM   = 3'd2,
      S_RUN   = 3'd3,
      S_DONE  = 3'd4,
      S_COOL  = 3'd5,
      S_FAULT = 3'd6
   } state_t;

   state_t            state_q, state_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [PEND_W-1:0] pending_q, pending_d;
   logic              overflow_q, overflow_d;
   logic              timer_en_q, timer_en_d;
   logic              timer_clr_q, timer_clr_d;
   logic              motor_on_q, motor_on_d;
   logic              feed_done_q, feed_done_d;
   logic              busy_q, busy_d;
   logic              fault_q, fault_d;
   logic              req_inc, req_dec, flush;

   // Next state, queue bookkeeping and Moore output decode of the next state
   always_comb begin
      state_d     = state_q;
      tmo_d       = tmo_q;
      pending_d   = pending_q;
      overflow_d  = overflow_q;
      req_inc     = 1'b0;
      req_dec     = 1'b0;
      flush       = 1'b0;
      timer_en_d  = 1'b0;
      timer_clr_d = 1'b0;
      motor_on_d  = 1'b0;
      feed_done_d = 1'b0;
      busy_d      = 1'b0;
      fault_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (pending_q != '0) state_d = S_CLEAR;
         end
         S_CLEAR: state_d = S_ARM;
         S_ARM: begin
            if (bus.switch_f_c)                           state_d = S_RUN;
            else if (tmo_q == TMO_W'(ARM_TIMEOUT - 1))    state_d = S_FAULT;
         end
         S_RUN: begin
            // A falling active flag is only a success if the timer reached its terminal count
            if (!bus.switch_f_c)
               state_d = (bus.count_in == CNT_W'(FOOD_TIME)) ? S_DONE : S_FAULT;
            else if (tmo_q == TMO_W'(RUN_TIMEOUT - 1))
               state_d = S_FAULT;
         end
         S_DONE: state_d = S_COOL;
         S_COOL: begin
            if (tmo_q == TMO_W'(COOLDOWN - 1)) state_d = S_IDLE;
         end
         S_FAULT: begin
            if (bus.fault_clear) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d != state_q)              tmo_d = '0;
      else if (tmo_q != TMO_W'(TMO_MAX))   tmo_d = tmo_q + TMO_W'(1);

      flush   = (state_q == S_FAULT) && bus.fault_clear;
      req_inc = bus.feed_req && (state_q != S_FAULT);
      req_dec = (state_q == S_RUN) && (state_d == S_DONE) && (pending_q != '0);

      if (flush) begin
         pending_d  = '0;
         overflow_d = 1'b0;
      end else if (req_inc && !req_dec) begin
         if (pending_q == PEND_W'(MAX_PENDING)) overflow_d = 1'b1;
         else                                   pending_d  = pending_q + PEND_W'(1);
      end else if (req_dec && !req_inc) begin
         pending_d = pending_q - PEND_W'(1);
      end

      timer_en_d  = (state_d == S_ARM) || (state_d == S_RUN);
      timer_clr_d = (state_d == S_CLEAR) || (state_d == S_FAULT);
      motor_on_d  = (state_d == S_RUN);
      feed_done_d = (state_d == S_DONE);
      busy_d      = (state_d != S_IDLE) && (state_d != S_FAULT);
      fault_d     = (state_d == S_FAULT);
   end

   // State, counters and registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         tmo_q       <= '0;
         pending_q   <= '0;
         overflow_q  <= 1'b0;
         timer_en_q  <= 1'b0;
         timer_clr_q <= 1'b0;
         motor_on_q  <= 1'b0;
         feed_done_q <= 1'b0;
         busy_q      <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         tmo_q       <= tmo_d;
         pending_q   <= pending_d;
         overflow_q  <= overflow_d;
         timer_en_q  <= timer_en_d;
         timer_clr_q <= timer_clr_d;
         motor_on_q  <= motor_on_d;
         feed_done_q <= feed_done_d;
         busy_q      <= busy_d;
         fault_q     <= fault_d;
      end
   end

   assign bus.timer_en  = timer_en_q;
   assign bus.timer_clr = timer_clr_q;
   assign bus.motor_on  = motor_on_q;
   assign bus.feed_done = feed_done_q;
   assign bus.busy      = busy_q;
   assign bus.pending   = pending_q;
   assign bus.overflow  = overflow_q;
   assign bus.fault     = fault_q;

endmodule

// File: tb/tb_food_dispense_ctrl.sv
// Bench for food_dispense_ctrl: a food timer model, a per-feed timeline model of the
// expected outputs checked every cycle, and directed scenarios with literal expectations.
module tb_food_dispense_ctrl;

   localparam int unsigned FOOD_TIME   = 10;
   localparam int unsigned MAX_PENDING = 3;
   localparam int unsigned ARM_TIMEOUT = 4;
   localparam int unsigned RUN_TIMEOUT = 16;
   localparam int unsigned COOLDOWN    = 5;
   localparam int unsigned DROP_AT     = 6;

   // Output vector order: timer_en, timer_clr, motor_on, feed_done, busy, fault
   typedef struct packed {
      logic en;
      logic clr;
      logic motor;
      logic done;
      logic busy;
      logic fault;
   } ovec_t;

   localparam ovec_t V_IDLE  = 6'b000000;
   localparam ovec_t V_CLEAR = 6'b010010;
   localparam ovec_t V_ARM   = 6'b100010;
   localparam ovec_t V_RUN   = 6'b101010;
   localparam ovec_t V_DONE  = 6'b000110;
   localparam ovec_t V_COOL  = 6'b000010;
   localparam ovec_t V_FAULT = 6'b010001;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   food_dispense_ctrl_if bus ();

   food_dispense_ctrl #(
      .FOOD_TIME  (FOOD_TIME),
      .MAX_PENDING(MAX_PENDING),
      .ARM_TIMEOUT(ARM_TIMEOUT),
      .RUN_TIMEOUT(RUN_TIMEOUT),
      .COOLDOWN   (COOLDOWN)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   // Food timer model; mode 0 normal, 1 never starts, 2 drops early at DROP_AT, 3 never drops
   int         timer_mode = 0;
   logic [3:0] t_cnt;
   logic       t_act;
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         t_cnt <= 4'd0;
         t_act <= 1'b0;
      end else if (bus.timer_clr) begin
         t_cnt <= 4'd0;
         t_act <= 1'b0;
      end else if (bus.timer_en) begin
         case (timer_mode)
            1: t_act <= 1'b0;
            2: if (t_cnt == 4'(DROP_AT)) t_act <= 1'b0;
               else begin t_cnt <= t_cnt + 4'd1; t_act <= 1'b1; end
            3: begin
               if (t_cnt < 4'(FOOD_TIME)) t_cnt <= t_cnt + 4'd1;
               t_act <= 1'b1;
            end
            default: if (t_cnt < 4'(FOOD_TIME)) begin t_cnt <= t_cnt + 4'd1; t_act <= 1'b1; end
                     else t_act <= 1'b0;
         endcase
      end
   end
   assign bus.switch_f_c = t_act;
   assign bus.count_in   = t_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc = 0, n_motor = 0, n_done = 0, n_clear = 0, n_en = 0, n_cool = 0;
   int done_cyc[$];

   // Expected-output model: each feed expands into a timeline of per-cycle output vectors
   ovec_t      exp_q[$];
   ovec_t      cur;
   logic [1:0] m_pend;
   logic       m_ovf;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      cur    = V_IDLE;
      m_pend = 2'd0;
      m_ovf  = 1'b0;
   endtask

   task automatic push_feed(input int mode);
      int arm_n, run_n;
      arm_n = (mode == 1) ? ARM_TIMEOUT : 2;
      run_n = (mode == 0) ? FOOD_TIME : (mode == 2) ? DROP_AT : (mode == 3) ? RUN_TIMEOUT : 0;
      exp_q.push_back(V_CLEAR);
      for (int i = 0; i < arm_n; i++) exp_q.push_back(V_ARM);
      for (int i = 0; i < run_n; i++) exp_q.push_back(V_RUN);
      if (mode == 0) begin
         exp_q.push_back(V_DONE);
         for (int i = 0; i < int'(COOLDOWN); i++) exp_q.push_back(V_COOL);
         exp_q.push_back(V_IDLE);
      end else begin
         exp_q.push_back(V_FAULT);
      end
   endtask

   task automatic model_step();
      ovec_t nxt;
      logic  inc, dec;
      if (cur.fault)             nxt = bus.fault_clear ? V_IDLE : V_FAULT;
      else if (exp_q.size() > 0) nxt = exp_q.pop_front();
      else if (m_pend != 2'd0) begin
         push_feed(timer_mode);
         nxt = exp_q.pop_front();
      end else nxt = V_IDLE;
      inc = bus.feed_req && !cur.fault;
      dec = nxt.done;
      if (cur.fault && bus.fault_clear) begin
         m_pend = 2'd0;
         m_ovf  = 1'b0;
      end else if (inc && !dec) begin
         if (m_pend < 2'(MAX_PENDING)) m_pend = m_pend + 2'd1;
         else                          m_ovf  = 1'b1;
      end else if (dec && !inc) begin
         m_pend = m_pend - 2'd1;
      end
      cur = nxt;
   endtask

   // One clock: compare at the falling edge, advance the model at the rising edge
   task automatic tick();
      ovec_t dv;
      @(negedge clock);
      if (!reset) begin
         cyc++;
         dv = {bus.timer_en, bus.timer_clr, bus.motor_on, bus.feed_done, bus.busy, bus.fault};
         check("cycle_outputs", 32'({dv, bus.pending, bus.overflow}), 32'({cur, m_pend, m_ovf}));
         check("en_clr_exclusive", 32'(bus.timer_en & bus.timer_clr), 32'd0);
         if (bus.motor_on) n_motor++;
         if (bus.timer_en) n_en++;
         if (bus.timer_clr && bus.busy) n_clear++;
         if (dv == V_COOL) n_cool++;
         if (bus.feed_done) begin
            n_done++;
            done_cyc.push_back(cyc);
         end
      end
      @(posedge clock);
      if (!reset) model_step();
      #2;
   endtask

   function automatic logic cond(input int what);
      case (what)
         0:       return !bus.busy && !bus.fault && (bus.pending == 2'd0);
         1:       return bus.fault;
         2:       return bus.motor_on && (bus.count_in == 4'd5);
         default: return bus.busy;
      endcase
   endfunction

   task automatic wait_for(input int what, input int budget, input string name);
      int n = 0;
      while (!cond(what) && n < budget) begin
         tick();
         n++;
      end
      check(name, 32'(cond(what)), 32'd1);
   endtask

   task automatic feed();
      bus.feed_req = 1'b1;
      tick();
      bus.feed_req = 1'b0;
   endtask

   task automatic clear_fault();
      bus.fault_clear = 1'b1;
      tick();
      bus.fault_clear = 1'b0;
   endtask

   int m0, d0, c0, e0, k0, q0;

   initial begin
      bus.feed_req    = 1'b0;
      bus.fault_clear = 1'b0;
      #1 reset = 1'b1;
      model_reset();
      tick();
      tick();
      check("reset_outputs", 32'({bus.timer_en, bus.timer_clr, bus.motor_on, bus.feed_done,
                                  bus.busy, bus.fault, bus.pending, bus.overflow}), 32'd0);
      reset = 1'b0;
      tick();

      // 1: single feed with a well-behaved timer
      m0 = n_motor; d0 = n_done; c0 = n_clear; k0 = n_cool;
      feed();
      check("t1_pending_one", 32'(bus.pending), 32'd1);
      wait_for(0, 100, "t1_back_to_idle");
      check("t1_motor_cycles", 32'(n_motor - m0), 32'd10);
      check("t1_feed_done_count", 32'(n_done - d0), 32'd1);
      check("t1_clear_cycles", 32'(n_clear - c0), 32'd1);
      check("t1_cool_cycles", 32'(n_cool - k0), 32'(COOLDOWN));

      // 2: three back-to-back requests
      q0 = done_cyc.size();
      feed(); feed(); feed();
      check("t2_pending_three", 32'(bus.pending), 32'd3);
      check("t2_no_overflow", 32'(bus.overflow), 32'd0);
      wait_for(0, 200, "t2_back_to_idle");
      check("t2_feed_done_count", 32'(done_cyc.size() - q0), 32'd3);
      for (int i = q0 + 1; i < done_cyc.size(); i++)
         check("t2_done_spacing", 32'((done_cyc[i] - done_cyc[i-1]) >= int'(COOLDOWN + 2)), 32'd1);

      // 3: four requests, one dropped at the full queue
      d0 = n_done;
      feed(); feed(); feed(); feed();
      check("t3_pending_saturated", 32'(bus.pending), 32'd3);
      check("t3_overflow_set", 32'(bus.overflow), 32'd1);
      wait_for(0, 200, "t3_back_to_idle");
      check("t3_feeds_served", 32'(n_done - d0), 32'd3);
      check("t3_overflow_sticky", 32'(bus.overflow), 32'd1);

      // 4: timer never starts -> ARM timeout
      timer_mode = 1;
      e0 = n_en;
      feed();
      wait_for(1, 50, "t4_fault_reached");
      check("t4_arm_cycles", 32'(n_en - e0), 32'(ARM_TIMEOUT));
      check("t4_fault_outputs", 32'({bus.fault, bus.motor_on, bus.timer_clr, bus.timer_en}), 32'b1010);
      feed();
      check("t4_req_ignored_in_fault", 32'(bus.pending), 32'd1);
      bus.feed_req = 1'b1;
      clear_fault();
      bus.feed_req = 1'b0;
      check("t4_after_clear", 32'({bus.fault, bus.busy, bus.pending, bus.overflow}), 32'd0);
      tick(); tick(); tick();
      check("t4_stays_idle", 32'(bus.busy), 32'd0);

      // 5a: timer drops its flag early
      timer_mode = 2;
      m0 = n_motor;
      feed();
      wait_for(1, 60, "t5_drop_fault");
      check("t5_drop_run_cycles", 32'(n_motor - m0), 32'(DROP_AT));
      check("t5_count_at_drop", 32'(bus.count_in), 32'(DROP_AT));
      clear_fault();

      // 5b: timer flag stuck high -> RUN timeout
      timer_mode = 3;
      m0 = n_motor;
      feed();
      wait_for(1, 80, "t5_stuck_fault");
      check("t5_stuck_run_cycles", 32'(n_motor - m0), 32'(RUN_TIMEOUT));
      clear_fault();

      // 6: reset mid-RUN, then restart
      timer_mode = 0;
      feed();
      wait_for(2, 60, "t6_reach_count5");
      reset = 1'b1;
      model_reset();
      #1;
      check("t6_async_reset_outputs", 32'({bus.timer_en, bus.timer_clr, bus.motor_on, bus.feed_done,
                                           bus.busy, bus.fault, bus.pending, bus.overflow}), 32'd0);
      tick(); tick();
      reset = 1'b0;
      tick();
      d0 = n_done;
      feed();
      wait_for(3, 10, "t6_restart_busy");
      check("t6_restart_in_clear", 32'({bus.timer_clr, bus.timer_en}), 32'b10);
      wait_for(0, 100, "t6_back_to_idle");
      check("t6_restart_feed_done", 32'(n_done - d0), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
